// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO (first-word-fall-through) with RTS hysteresis and sticky overflow.
// Optional per-drop counter enabled by defining UART_RX_FIFO_OVF_COUNT_EN.
module uart_rx_fifo #(
  parameter int DataSize     = 8,
  parameter int AddrWidth    = 4,
  parameter int RtsHighWater = 12,
  parameter int RtsLowWater  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DataSize-1:0]  i_wr_data,
  input  logic                 i_wr_valid,
  output logic [DataSize-1:0]  o_rd_data,
  output logic                 o_rd_data_valid,
  input  logic                 i_rd_data_ready,
  output logic [AddrWidth:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_rts_n,
  output logic                 o_overflow,
  output logic [7:0]           o_overflow_count
);

  localparam int Depth = 1 << AddrWidth;
  localparam logic [AddrWidth:0]   DepthLvl = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth:0]   HighLvl  = (AddrWidth + 1)'(RtsHighWater);
  localparam logic [AddrWidth:0]   LowLvl   = (AddrWidth + 1)'(RtsLowWater);
  localparam logic [AddrWidth:0]   OneLvl   = (AddrWidth + 1)'(1);
  localparam logic [AddrWidth:0]   ZeroLvl  = (AddrWidth + 1)'(0);
  localparam logic [AddrWidth-1:0] OnePtr   = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] ZeroPtr  = AddrWidth'(0);

  typedef enum logic {
    RTS_GO   = 1'b0,
    RTS_STOP = 1'b1
  } rts_state_e;

  logic [DataSize-1:0]  mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  rts_state_e           rts_q, rts_d;

  logic rd_fire_s;
  logic wr_acc_s;
  logic drop_s;
  logic full_s;
  logic empty_s;

  // Handshake decode, pointer advance and fill-level update
  always_comb begin
    empty_s   = (count_q == ZeroLvl);
    full_s    = (count_q == DepthLvl);
    rd_fire_s = !empty_s && i_rd_data_ready;
    // A read in the same cycle frees the slot, so a full FIFO can still accept
    wr_acc_s  = i_wr_valid && (!full_s || rd_fire_s);
    drop_s    = i_wr_valid && !wr_acc_s;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop_s;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + OnePtr;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + OnePtr;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc_s, rd_fire_s})
      2'b10:   count_d = count_q + OneLvl;
      2'b01:   count_d = count_q - OneLvl;
      default: count_d = count_q;
    endcase
  end

  // RTS hysteresis: decided on the upcoming fill level so it moves with o_count
  always_comb begin
    rts_d = rts_q;
    case (rts_q)
      RTS_GO: begin
        if (count_d >= HighLvl) begin
          rts_d = RTS_STOP;
        end else begin
          rts_d = RTS_GO;
        end
      end
      RTS_STOP: begin
        if (count_d <= LowLvl) begin
          rts_d = RTS_GO;
        end else begin
          rts_d = RTS_STOP;
        end
      end
      default: rts_d = RTS_GO;
    endcase
  end

  // Control state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= ZeroPtr;
      rd_ptr_q   <= ZeroPtr;
      count_q    <= ZeroLvl;
      overflow_q <= 1'b0;
      rts_q      <= RTS_GO;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rts_q      <= rts_d;
    end
  end

  // Storage array; contents are meaningless after reset so it has no reset branch
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc_s) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

`ifdef UART_RX_FIFO_OVF_COUNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating dropped-byte counter
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop_s && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Dropped-byte counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_cnt_q <= 8'h00;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign o_overflow_count = ovf_cnt_q;
`else
  assign o_overflow_count = 8'h00;
`endif

  assign o_rd_data       = mem_q[rd_ptr_q];
  assign o_rd_data_valid = !empty_s;
  assign o_count         = count_q;
  assign o_full          = full_s;
  assign o_empty         = empty_s;
  assign o_rts_n         = (rts_q == RTS_STOP);
  assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_wr_valid = 1'b0;
  logic       i_rd_data_ready = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_data_valid;
  logic [4:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_rts_n;
  logic       o_overflow;
  logic [7:0] o_overflow_count;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_wr_data        (i_wr_data),
    .i_wr_valid       (i_wr_valid),
    .o_rd_data        (o_rd_data),
    .o_rd_data_valid  (o_rd_data_valid),
    .i_rd_data_ready  (i_rd_data_ready),
    .o_count          (o_count),
    .o_full           (o_full),
    .o_empty          (o_empty),
    .o_rts_n          (o_rts_n),
    .o_overflow       (o_overflow),
    .o_overflow_count (o_overflow_count)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: the FIFO is just a queue of bytes
  logic [7:0] mq[$];
  bit         m_rts = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_drops = 0;

  function automatic int exp_ovf_count();
`ifdef UART_RX_FIFO_OVF_COUNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_ovf_lit(input int n);
`ifdef UART_RX_FIFO_OVF_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic wv, input logic [7:0] wd, input logic rdy);
    bit fire;
    bit acc;
    if (rst) begin
      mq.delete();
      m_rts   = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      fire = (mq.size() > 0) && rdy;
      acc  = wv && ((mq.size() < 16) || fire);
      if (fire) void'(mq.pop_front());
      if (acc) mq.push_back(wd);
      if (wv && !acc) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
      if (!m_rts && mq.size() >= 12) m_rts = 1'b1;
      else if (m_rts && mq.size() <= 4) m_rts = 1'b0;
    end
  endtask

  task automatic cycle(input logic rst, input logic wv, input logic [7:0] wd, input logic rdy);
    i_rst           = rst;
    i_wr_valid      = wv;
    i_wr_data       = wd;
    i_rd_data_ready = rdy;
    @(posedge clk);
    #1;
    model_step(rst, wv, wd, rdy);
    cmp_en = 1'b1;
  endtask

  // Every-cycle comparison of the DUT against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count", 32'(o_count), 32'(mq.size()));
      chk("empty", 32'(o_empty), 32'(mq.size() == 0));
      chk("full", 32'(o_full), 32'(mq.size() == 16));
      chk("valid", 32'(o_rd_data_valid), 32'(mq.size() != 0));
      chk("rts_n", 32'(o_rts_n), 32'(m_rts));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("ovf_count", 32'(o_overflow_count), 32'(exp_ovf_count()));
      if (mq.size() > 0) chk("rd_data", 32'(o_rd_data), 32'(mq[0]));
    end
  end

  initial begin
    int wp;
    int rp;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("lit_rst_count", 32'(o_count), 32'd0);
    chk("lit_rst_empty", 32'(o_empty), 32'd1);
    chk("lit_rst_rts", 32'(o_rts_n), 32'd0);

    // Single byte latency and pass-through
    cycle(1'b0, 1'b1, 8'h41, 1'b1);
    chk("lit_41_valid", 32'(o_rd_data_valid), 32'd1);
    chk("lit_41_data", 32'(o_rd_data), 32'h41);
    chk("lit_41_count", 32'(o_count), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("lit_41_empty", 32'(o_empty), 32'd1);

    // Fill to full; RTS rises exactly when count reaches 12
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 10) chk("lit_fill_rts11", 32'(o_rts_n), 32'd0);
      if (i == 11) chk("lit_fill_rts12", 32'(o_rts_n), 32'd1);
    end
    chk("lit_fill_full", 32'(o_full), 32'd1);
    chk("lit_fill_count", 32'(o_count), 32'd16);

    // Drain in order; RTS falls exactly when count reaches 4
    for (int i = 0; i < 16; i++) begin
      chk("lit_drain_data", 32'(o_rd_data), 32'(i));
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      if (i == 10) chk("lit_drain_rts5", 32'(o_rts_n), 32'd1);
      if (i == 11) chk("lit_drain_rts4", 32'(o_rts_n), 32'd0);
    end
    chk("lit_drain_empty", 32'(o_empty), 32'd1);

    // Overflow while full, then write-through-read at full
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 1'b1, 8'hBB, 1'b0);
    chk("lit_ovf_flag", 32'(o_overflow), 32'd1);
    chk("lit_ovf_count", 32'(o_overflow_count), 32'(exp_ovf_lit(2)));
    chk("lit_ovf_keep", 32'(o_count), 32'd16);
    chk("lit_ovf_head", 32'(o_rd_data), 32'h00);
    cycle(1'b0, 1'b1, 8'hCC, 1'b1);
    chk("lit_cc_count", 32'(o_count), 32'd16);
    for (int i = 1; i < 16; i++) begin
      chk("lit_cc_drain", 32'(o_rd_data), 32'(i));
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("lit_cc_last", 32'(o_rd_data), 32'hCC);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("lit_cc_empty", 32'(o_empty), 32'd1);

    // Reset mid-fill wins over a simultaneous write
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    chk("lit_r9_count", 32'(o_count), 32'd9);
    chk("lit_r9_rts", 32'(o_rts_n), 32'd0);
    cycle(1'b1, 1'b1, 8'h77, 1'b1);
    chk("lit_r_count", 32'(o_count), 32'd0);
    chk("lit_r_empty", 32'(o_empty), 32'd1);
    chk("lit_r_full", 32'(o_full), 32'd0);
    chk("lit_r_valid", 32'(o_rd_data_valid), 32'd0);
    chk("lit_r_rts", 32'(o_rts_n), 32'd0);
    chk("lit_r_ovf", 32'(o_overflow), 32'd0);
    chk("lit_r_ovfcnt", 32'(o_overflow_count), 32'd0);
    cycle(1'b0, 1'b1, 8'h5A, 1'b0);
    chk("lit_r_next_valid", 32'(o_rd_data_valid), 32'd1);
    chk("lit_r_next_data", 32'(o_rd_data), 32'h5A);

    // Randomized traffic in phases of differing write/read pressure
    for (int ph = 0; ph < 8; ph++) begin
      case (ph)
        0: begin wp = 90;  rp = 30; end
        1: begin wp = 40;  rp = 80; end
        2: begin wp = 100; rp = 0;  end
        3: begin wp = 60;  rp = 60; end
        4: begin wp = 20;  rp = 90; end
        5: begin wp = 95;  rp = 50; end
        6: begin wp = 70;  rp = 40; end
        default: begin wp = 50; rp = 50; end
      endcase
      for (int c = 0; c < 300; c++) begin
        cycle(1'($urandom_range(0, 399) == 0),
              1'($urandom_range(0, 99) < wp),
              8'($urandom),
              1'($urandom_range(0, 99) < rp));
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DataSize, default 8: width of each buffered UART byte in bits.
REQ-002 Parameter AddrWidth, default 4: FIFO depth is 2**AddrWidth entries (16).
REQ-003 Parameter RtsHighWater, default 12: fill level at which o_rts_n goes high (stop sender).
REQ-004 Parameter RtsLowWater, default 4: fill level at which o_rts_n returns low; legal only if RtsLowWater < RtsHighWater <= 2**AddrWidth.
REQ-005 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_wr_data  input  DataSize  received byte from the UART receiver.
REQ-008 i_wr_valid  input  1  one-cycle "received" strobe; no backpressure toward the receiver.
REQ-009 o_rd_data  output  DataSize  head-of-FIFO byte to uart_mem_access i_rx_data.
REQ-010 o_rd_data_valid  output  1  head byte is present.
REQ-011 i_rd_data_ready  input  1  consumer accepts the head byte.
REQ-012 o_count  output  AddrWidth+1  current fill level, 0 to 2**AddrWidth.
REQ-013 o_full / o_empty  output  1 each  count == depth / count == 0.
REQ-014 o_rts_n  output  1  registered UART RTS, active-low (0 = send allowed).
REQ-015 o_overflow  output  1  sticky flag: at least one byte has been dropped.
REQ-016 o_overflow_count  output  8  number of dropped bytes (see Configuration).

Function
REQ-017 The FIFO SHALL be first-word-fall-through: o_rd_data_valid = !o_empty, and o_rd_data SHALL hold the oldest stored byte whenever valid is high.
REQ-018 A read fire SHALL be o_rd_data_valid && i_rd_data_ready; it advances the read pointer at that clock edge.
REQ-019 A write SHALL be accepted iff i_wr_valid && (!o_full || read fire in the same cycle).
REQ-020 A byte written into an empty FIFO SHALL appear on o_rd_data with o_rd_data_valid high in the cycle after the write strobe (latency 1).
REQ-021 Simultaneous accepted write and read fire SHALL leave o_count unchanged; write only: +1; read only: -1.
REQ-022 Read and write pointers SHALL be AddrWidth bits and wrap modulo 2**AddrWidth with no gap or duplicate.
REQ-023 i_wr_valid while full with no read fire SHALL drop i_wr_data, leave the contents unchanged, and set o_overflow at the next edge.
REQ-024 i_rd_data_ready while empty SHALL have no effect.
REQ-025 RTS hysteresis SHALL be a 2-state machine: GO (o_rts_n=0) -> STOP when next count >= RtsHighWater; STOP (o_rts_n=1) -> GO when next count <= RtsLowWater; otherwise hold.
REQ-026 o_rts_n SHALL be registered and change in the same edge that updates o_count.
REQ-027 The top level SHALL drive its external RTS output from (o_rts_n || !rx_data_ready), not from the receiver busy flag.

Reset
REQ-028 On i_rst high at a clock edge: pointers=0, o_count=0, o_empty=1, o_full=0, o_rd_data_valid=0, o_rts_n=0 (GO), o_overflow=0, o_overflow_count=0.
REQ-029 Reset SHALL take priority over any write or read in the same cycle; stored data is discarded.
REQ-030 o_rd_data value during and after reset is don't-care while o_rd_data_valid=0.

Configuration
REQ-031 Macro UART_RX_FIFO_OVF_COUNT_EN defined: o_overflow_count SHALL increment by 1 on each dropped byte and saturate at 255.
REQ-032 Macro undefined: o_overflow_count SHALL be constant 0 and no counter logic SHALL exist; o_overflow is unaffected.

Verification
REQ-033 Write 0x41 into an empty FIFO, ready=1 -> valid high next cycle with data 0x41, count 1, then empty after 1 cycle.
REQ-034 With ready=0, write 0x00..0x0F -> o_full=1 and count=16; o_rts_n goes 1 on the edge where count reaches 12.
REQ-035 Drain the full FIFO with ready=1 -> bytes 0x00..0x0F in order; o_rts_n returns 0 on the edge where count reaches 4.
REQ-036 FIFO full, write 0xAA and 0xBB with ready=0 -> both dropped, o_overflow=1, o_overflow_count=2 (0 when the macro is undefined).
REQ-037 FIFO full, write 0xCC with ready=1 in the same cycle -> 0xCC accepted, count stays 16, and 0xCC is read last.
REQ-038 Assert i_rst with count=9 and o_rts_n=0 -> all outputs take reset values on the next edge; the next write reappears with latency 1.
